// File: rtl/clk_ratio_monitor_pkg.sv
// Shared constants for the divided-clock monitor and the clock generator.
// Default ratios, lock threshold and error-counter width.
package clk_ratio_monitor_pkg;

  localparam int DEF_HALF10     = 1;
  localparam int DEF_HALF20     = 2;
  localparam int DEF_HALF40     = 4;
  localparam int DEF_CW         = 4;
  localparam int DEF_LOCK_EDGES = 4;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == cnt_t'(CNT_MAX)) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/clk_run_check.sv
// Level-run checker for one divided clock sampled as data.
// Flags runs that end too early or overstay the expected half-period.
module clk_run_check #(
  parameter int HALF = 2,
  parameter int CW   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic din,
  output logic toggle,
  output logic armed,
  output logic early,
  output logic late
);

  localparam logic [CW-1:0] HV  = CW'(HALF);
  localparam logic [CW-1:0] SAT = CW'(HALF + 1);

  logic          prev;
  logic [CW-1:0] run;

  always_comb begin
    toggle = din ^ prev;
    early  = enb && armed && toggle && (run < HV);
    late   = enb && armed && !toggle && (run == HV);
  end

  // prev keeps tracking while disabled so re-enabling sees no false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      run   <= '0;
      armed <= 1'b0;
    end else begin
      prev <= din;
      if (!enb) begin
        run   <= '0;
        armed <= 1'b0;
      end else if (toggle) begin
        run   <= CW'(1);
        armed <= 1'b1;
      end else if (run != SAT) begin
        run <= run + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_ratio_monitor.sv
// Monitors clk10/clk20/clk40 run lengths and phase from the master clock.
// Reports sticky errors, a saturating error count and lock status.
module clk_ratio_monitor
  import clk_ratio_monitor_pkg::*;
#(
  parameter int HALF10     = DEF_HALF10,
  parameter int HALF20     = DEF_HALF20,
  parameter int HALF40     = DEF_HALF40,
  parameter int CW         = DEF_CW,
  parameter int LOCK_EDGES = DEF_LOCK_EDGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       clk10,
  input  logic       clk20,
  input  logic       clk40,
  output logic       locked,
  output logic       err10,
  output logic       err20,
  output logic       err40,
  output logic       phase_err,
  output logic [7:0] err_count
);

  localparam int LW = $clog2(LOCK_EDGES + 1);
  localparam logic [LW-1:0] LOCK_V = LW'(LOCK_EDGES);

  logic t10, t20, t40;
  logic a10, a20, a40;
  logic e10, e20, e40;
  logic l10, l20, l40;

  clk_run_check #(.HALF(HALF10), .CW(CW)) u_c10 (
    .clk(clk), .rst(rst), .enb(enb), .din(clk10),
    .toggle(t10), .armed(a10), .early(e10), .late(l10)
  );

  clk_run_check #(.HALF(HALF20), .CW(CW)) u_c20 (
    .clk(clk), .rst(rst), .enb(enb), .din(clk20),
    .toggle(t20), .armed(a20), .early(e20), .late(l20)
  );

  clk_run_check #(.HALF(HALF40), .CW(CW)) u_c40 (
    .clk(clk), .rst(rst), .enb(enb), .din(clk40),
    .toggle(t40), .armed(a40), .early(e40), .late(l40)
  );

  logic          all_armed;
  logic          bad10, bad20, bad40;
  logic          ph;
  logic          ev;
  logic [LW-1:0] clean;
  logic [LW-1:0] clean_nxt;

  always_comb begin
    all_armed = a10 & a20 & a40;
    bad10     = e10 | l10;
    bad20     = e20 | l20;
    bad40     = e40 | l40;
    // slower edges must coincide with every faster edge
    ph        = enb && all_armed &&
                ((t40 && !(t20 && t10)) || (t20 && !t10));
    ev        = bad10 | bad20 | bad40 | ph;
    clean_nxt = clean;
    if (!enb || ev)
      clean_nxt = '0;
    else if (all_armed && t40 && clean != LOCK_V)
      clean_nxt = clean + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clean     <= '0;
      locked    <= 1'b0;
      err10     <= 1'b0;
      err20     <= 1'b0;
      err40     <= 1'b0;
      phase_err <= 1'b0;
      err_count <= '0;
    end else begin
      clean  <= clean_nxt;
      locked <= (clean_nxt == LOCK_V);
      if (bad10) err10     <= 1'b1;
      if (bad20) err20     <= 1'b1;
      if (bad40) err40     <= 1'b1;
      if (ph)    phase_err <= 1'b1;
      if (ev)    err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: divider/stuck/random stimulus,
// checked every cycle against an edge-timestamp reference model.
module tb_clk_ratio_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       c10, c20, c40;
  logic       locked;
  logic       err10, err20, err40, phase_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  clk_ratio_monitor dut (
    .clk(clk), .rst(rst), .enb(enb),
    .clk10(c10), .clk20(c20), .clk40(c40),
    .locked(locked), .err10(err10), .err20(err20), .err40(err40),
    .phase_err(phase_err), .err_count(err_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: each channel keeps the sample index of its last edge
  int  half [3] = '{1, 2, 4};
  int  lock_edges = 4;
  int  n = 0;
  bit  mprev [3];
  bit  marm  [3];
  int  medge [3];
  bit  merr  [3];
  bit  mph;
  int  mcnt;
  int  mclean;
  bit  mlock;
  bit  mon_on = 0;

  always @(posedge clk) begin
    bit v [3];
    bit t [3];
    bit e;
    bit ph;
    bit all;
    v = '{c10, c20, c40};
    n++;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mprev[i] = 0; marm[i] = 0; merr[i] = 0; medge[i] = 0;
      end
      mph = 0; mcnt = 0; mclean = 0; mlock = 0;
    end else begin
      e = 0;
      for (int i = 0; i < 3; i++) t[i] = (v[i] != mprev[i]);
      for (int i = 0; i < 3; i++)
        if (enb && marm[i]) begin
          if (t[i] && (n - medge[i]) < half[i]) begin merr[i] = 1; e = 1; end
          if (!t[i] && (n - medge[i]) == half[i]) begin merr[i] = 1; e = 1; end
        end
      all = marm[0] && marm[1] && marm[2];
      ph = enb && all && ((t[2] && !(t[1] && t[0])) || (t[1] && !t[0]));
      if (ph) begin mph = 1; e = 1; end
      if (e && mcnt < 255) mcnt++;
      if (!enb || e) mclean = 0;
      else if (all && t[2] && mclean < lock_edges) mclean++;
      mlock = (mclean == lock_edges);
      for (int i = 0; i < 3; i++) begin
        if (!enb) marm[i] = 0;
        else if (t[i]) begin marm[i] = 1; medge[i] = n; end
        mprev[i] = v[i];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("locked", locked, mlock);
      chk("err10", err10, merr[0]);
      chk("err20", err20, merr[1]);
      chk("err40", err40, merr[2]);
      chk("phase_err", phase_err, mph);
      chk("err_count", err_count, mcnt);
    end
  end

  // stimulus: mode 0 divider, 1 all-zero, 2 random
  int          mode = 0;
  bit          f20 = 0;
  bit          inv40 = 0;
  logic [31:0] cnt = 0;

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      case (mode)
        0: begin
          c10 = cnt[0];
          c20 = f20 ? 1'b1 : cnt[1];
          c40 = cnt[2] ^ inv40;
        end
        1: {c40, c20, c10} = 3'b000;
        default: {c40, c20, c10} = 3'($urandom);
      endcase
    end
  endtask

  task automatic wait_lock(input string tag);
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      if (locked === 1'b1) break;
    end
    chk(tag, locked, 1);
  endtask

  int m_at;

  initial begin
    rst = 1; enb = 0; c10 = 0; c20 = 0; c40 = 0;
    @(posedge clk);
    #1;
    mon_on = 1;
    cyc(7);
    chk("rst_count", err_count, 0);
    chk("rst_locked", locked, 0);
    rst = 0;
    cyc(2);
    enb = 1;
    wait_lock("lock_init");
    chk("init_count", err_count, 0);
    chk("init_err40", err40, 0);
    cyc(8);

    f20 = 1;
    cyc(6);
    f20 = 0;
    cyc(12);
    chk("stuck20_err20", err20, 1);
    chk("stuck20_phase", phase_err, 1);

    enb = 0;
    cyc(10);
    chk("enb_off_locked", locked, 0);
    chk("enb_off_err20", err20, 1);
    chk("enb_off_count", err_count, mcnt);
    enb = 1;
    wait_lock("relock");
    chk("relock_err20", err20, 1);
    cyc(5);

    rst = 1; enb = 0;
    cyc(1);
    chk("pulse_count", err_count, 0);
    chk("pulse_err20", err20, 0);
    chk("pulse_phase", phase_err, 0);
    chk("pulse_locked", locked, 0);
    rst = 0;
    cyc(2);
    enb = 1;
    wait_lock("lock_after_rst");
    cyc(3);

    while (((cnt + 1) % 4) != 3) cyc(1);
    inv40 = 1;
    cyc(2);
    chk("glitch_err40", err40, 1);
    chk("glitch_phase", phase_err, 1);
    chk("glitch_count", err_count, 1);
    cyc(20);

    rst = 1; enb = 0; inv40 = 0;
    cyc(1);
    rst = 0;
    cyc(2);
    enb = 1;
    wait_lock("lock_pre_stuck");
    mode = 1;
    cyc(100);
    m_at = mcnt;
    cyc(500);
    chk("stuck_err10", err10, 1);
    chk("stuck_err20", err20, 1);
    chk("stuck_err40", err40, 1);
    chk("stuck_norepeat", err_count, m_at);

    mode = 2;
    cyc(500);
    chk("sat_count", err_count, 255);
    cyc(20);
    chk("sat_hold", err_count, 255);

    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
